// File: rtl/lap_log_ctrl_pkg.sv
// lap_log_ctrl_pkg: shared chronometer definitions for the lap log controller
package lap_log_ctrl_pkg;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_ADDR_BITS  = 9;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    PRESENT = 2'd2
  } state_e;
endpackage

// File: rtl/lap_log_ctrl.sv
// lap_log_ctrl: logs lap times into a BRAM in arrival order and plays them back oldest-first
module lap_log_ctrl
  import lap_log_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_BITS  = DEF_ADDR_BITS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  lap_valid,
  input  logic [DATA_WIDTH-1:0] lap_time,
  input  logic                  clear,
  input  logic                  recall_next,
  output logic                  recall_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic [ADDR_BITS:0]    lap_count,
  output logic                  overflow,
  output logic [ADDR_BITS-1:0]  ram_wr_addr,
  output logic [DATA_WIDTH-1:0] ram_wr_data,
  output logic                  ram_we,
  output logic [ADDR_BITS-1:0]  ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_rd_data
);
  localparam int CW = ADDR_BITS + 1;
  state_e                  state_q;
  logic [ADDR_BITS-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q;
  logic [CW-1:0]           lap_count_q, lap_count_d;
  logic                    overflow_q, overflow_d;
  logic                    out_valid_q, out_last_q;
  logic [DATA_WIDTH-1:0]   out_data_q;
  logic                    full, is_last;
  // Full is exactly lap_count == DEPTH, i.e. the top count bit set.
  assign full         = lap_count_q[ADDR_BITS];
  assign is_last      = {1'b0, rd_ptr_q} + CW'(1) == lap_count_q;
  assign ram_we       = lap_valid & ~clear & ~full;
  assign ram_wr_addr  = wr_ptr_q;
  assign ram_wr_data  = lap_time;
  assign ram_rd_addr  = rd_ptr_q;
  assign recall_ready = (state_q == IDLE) & |lap_count_q;
  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign out_last     = out_last_q;
  assign lap_count    = lap_count_q;
  assign overflow     = overflow_q;
  // Write-side next state: clear wins, a full log drops the lap and flags overflow.
  always_comb begin
    wr_ptr_d    = clear ? '0 : wr_ptr_q + ADDR_BITS'(ram_we);
    lap_count_d = clear ? '0 : lap_count_q + CW'(ram_we);
    overflow_d  = ~clear & (overflow_q | (lap_valid & full));
  end
  // Write-side state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      lap_count_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      lap_count_q <= lap_count_d;
      overflow_q  <= overflow_d;
    end
  end
  // Read FSM: the BRAM samples rd_ptr on the accept edge, data is captured one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rd_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else if (clear) begin
      state_q     <= IDLE;
      rd_ptr_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      case (state_q)
        IDLE:    state_q <= (recall_next & recall_ready) ? FETCH : IDLE;
        FETCH: begin
          out_data_q  <= ram_rd_data;
          out_last_q  <= is_last;
          rd_ptr_q    <= is_last ? '0 : rd_ptr_q + ADDR_BITS'(1);
          out_valid_q <= 1'b1;
          state_q     <= PRESENT;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lap_log_ctrl.sv
// tb_lap_log_ctrl: directed table-driven bench with BRAM models for a deep and a 4-entry log
module tb_lap_log_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        lv, clr, rn, rdy, ov, ol, ovf, we;
  logic [15:0] lt, od, wd, rd;
  logic [9:0]  cnt;
  logic [8:0]  wa, ra;
  logic [15:0] mem [512];

  lap_log_ctrl u_dut (
    .clk(clk), .rst_n(rst_n), .lap_valid(lv), .lap_time(lt), .clear(clr),
    .recall_next(rn), .recall_ready(rdy), .out_valid(ov), .out_data(od),
    .out_last(ol), .lap_count(cnt), .overflow(ovf), .ram_wr_addr(wa),
    .ram_wr_data(wd), .ram_we(we), .ram_rd_addr(ra), .ram_rd_data(rd)
  );

  always @(posedge clk) begin
    if (we) mem[wa] <= wd;
    rd <= mem[ra];
  end

  logic        s_lv, s_clr, s_rn, s_rdy, s_ov, s_ol, s_ovf, s_we;
  logic [15:0] s_lt, s_od, s_wd, s_rd;
  logic [2:0]  s_cnt;
  logic [1:0]  s_wa, s_ra;
  logic [15:0] s_mem [4];

  lap_log_ctrl #(.DATA_WIDTH(16), .ADDR_BITS(2)) u_small (
    .clk(clk), .rst_n(rst_n), .lap_valid(s_lv), .lap_time(s_lt), .clear(s_clr),
    .recall_next(s_rn), .recall_ready(s_rdy), .out_valid(s_ov), .out_data(s_od),
    .out_last(s_ol), .lap_count(s_cnt), .overflow(s_ovf), .ram_wr_addr(s_wa),
    .ram_wr_data(s_wd), .ram_we(s_we), .ram_rd_addr(s_ra), .ram_rd_data(s_rd)
  );

  always @(posedge clk) begin
    if (s_we) s_mem[s_wa] <= s_wd;
    s_rd <= s_mem[s_ra];
  end

  typedef struct {
    logic        lv;
    logic [15:0] lt;
    logic        clr, rn;
    logic        rdy, ov;
    logic [15:0] od;
    logic        ol;
    logic [9:0]  cnt;
    logic        we;
    logic [8:0]  wa, ra;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic vec_t mk(input logic i_lv, input logic [15:0] i_lt, input logic i_clr,
                              input logic i_rn, input logic e_rdy, input logic e_ov,
                              input logic [15:0] e_od, input logic e_ol, input logic [9:0] e_cnt,
                              input logic e_we, input logic [8:0] e_wa, input logic [8:0] e_ra);
    vec_t v;
    v.lv = i_lv; v.lt = i_lt; v.clr = i_clr; v.rn = i_rn;
    v.rdy = e_rdy; v.ov = e_ov; v.od = e_od; v.ol = e_ol;
    v.cnt = e_cnt; v.we = e_we; v.wa = e_wa; v.ra = e_ra;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  initial begin
    {lv, clr, rn, s_lv, s_clr, s_rn} = '0;
    lt = '0;
    s_lt = '0;
    //            lv  lt      clr rn   rdy ov  od      ol cnt we wa ra
    tbl.push_back(mk(1, 'h0010, 0, 0,   0, 0, 'h0000, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 'h0020, 0, 0,   1, 0, 'h0000, 0, 1, 1, 1, 0));
    tbl.push_back(mk(1, 'h0030, 0, 0,   1, 0, 'h0000, 0, 2, 1, 2, 0));
    tbl.push_back(mk(0, 'h0000, 0, 1,   1, 0, 'h0000, 0, 3, 0, 3, 0));
    tbl.push_back(mk(0, 'h0000, 0, 0,   0, 0, 'h0000, 0, 3, 0, 3, 0));
    tbl.push_back(mk(0, 'h0000, 0, 0,   0, 1, 'h0010, 0, 3, 0, 3, 1));
    tbl.push_back(mk(0, 'h0000, 0, 1,   1, 0, 'h0010, 0, 3, 0, 3, 1));
    tbl.push_back(mk(0, 'h0000, 0, 0,   0, 0, 'h0010, 0, 3, 0, 3, 1));
    tbl.push_back(mk(0, 'h0000, 0, 0,   0, 1, 'h0020, 0, 3, 0, 3, 2));
    tbl.push_back(mk(0, 'h0000, 0, 1,   1, 0, 'h0020, 0, 3, 0, 3, 2));
    tbl.push_back(mk(0, 'h0000, 0, 0,   0, 0, 'h0020, 0, 3, 0, 3, 2));
    tbl.push_back(mk(0, 'h0000, 0, 0,   0, 1, 'h0030, 1, 3, 0, 3, 0));
    tbl.push_back(mk(0, 'h0000, 0, 1,   1, 0, 'h0030, 1, 3, 0, 3, 0));
    tbl.push_back(mk(0, 'h0000, 0, 0,   0, 0, 'h0030, 1, 3, 0, 3, 0));
    tbl.push_back(mk(0, 'h0000, 0, 0,   0, 1, 'h0010, 0, 3, 0, 3, 1));
    tbl.push_back(mk(1, 'h0099, 1, 0,   1, 0, 'h0010, 0, 3, 0, 3, 1));
    tbl.push_back(mk(1, 'h0040, 0, 0,   0, 0, 'h0010, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 'h0050, 0, 1,   1, 0, 'h0010, 0, 1, 1, 1, 0));
    tbl.push_back(mk(0, 'h0000, 0, 0,   0, 0, 'h0010, 0, 2, 0, 2, 0));
    tbl.push_back(mk(0, 'h0000, 0, 0,   0, 1, 'h0040, 0, 2, 0, 2, 1));
    tbl.push_back(mk(0, 'h0000, 0, 1,   1, 0, 'h0040, 0, 2, 0, 2, 1));
    tbl.push_back(mk(0, 'h0000, 1, 0,   0, 0, 'h0040, 0, 2, 0, 2, 1));
    tbl.push_back(mk(0, 'h0000, 0, 0,   0, 0, 'h0040, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 'h0000, 0, 0,   0, 0, 'h0040, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 'h0111, 0, 0,   0, 0, 'h0040, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 'h0222, 0, 0,   1, 0, 'h0040, 0, 1, 1, 1, 0));
    tbl.push_back(mk(0, 'h0000, 0, 1,   1, 0, 'h0040, 0, 2, 0, 2, 0));
    tbl.push_back(mk(0, 'h0000, 0, 1,   0, 0, 'h0040, 0, 2, 0, 2, 0));
    tbl.push_back(mk(0, 'h0000, 0, 1,   0, 1, 'h0111, 0, 2, 0, 2, 1));
    tbl.push_back(mk(0, 'h0000, 0, 1,   1, 0, 'h0111, 0, 2, 0, 2, 1));
    tbl.push_back(mk(0, 'h0000, 0, 1,   0, 0, 'h0111, 0, 2, 0, 2, 1));
    tbl.push_back(mk(0, 'h0000, 0, 1,   0, 1, 'h0222, 1, 2, 0, 2, 0));
    tbl.push_back(mk(0, 'h0000, 0, 1,   1, 0, 'h0222, 1, 2, 0, 2, 0));
    tbl.push_back(mk(0, 'h0000, 0, 1,   0, 0, 'h0222, 1, 2, 0, 2, 0));
    tbl.push_back(mk(0, 'h0000, 0, 1,   0, 1, 'h0111, 0, 2, 0, 2, 1));
    tbl.push_back(mk(0, 'h0000, 0, 0,   1, 0, 'h0111, 0, 2, 0, 2, 1));

    repeat (2) @(negedge clk);
    #1;
    chk("rst rdy", rdy, 0);
    chk("rst ov", ov, 0);
    chk("rst cnt", cnt, 0);
    chk("rst we", we, 0);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      @(negedge clk);
      lv = tbl[i].lv; lt = tbl[i].lt; clr = tbl[i].clr; rn = tbl[i].rn;
      #1;
      chk($sformatf("r%0d rdy", i), rdy, tbl[i].rdy);
      chk($sformatf("r%0d ov", i), ov, tbl[i].ov);
      chk($sformatf("r%0d od", i), od, tbl[i].od);
      chk($sformatf("r%0d ol", i), ol, tbl[i].ol);
      chk($sformatf("r%0d cnt", i), cnt, tbl[i].cnt);
      chk($sformatf("r%0d ovf", i), ovf, 0);
      chk($sformatf("r%0d we", i), we, tbl[i].we);
      chk($sformatf("r%0d wa", i), wa, tbl[i].wa);
      chk($sformatf("r%0d wd", i), wd, tbl[i].lt);
      chk($sformatf("r%0d ra", i), ra, tbl[i].ra);
    end

    @(negedge clk);
    {lv, clr} = '0;
    rn = 1'b1;
    #1 chk("arst accept", rdy, 1);
    @(negedge clk);
    rn = 1'b0;
    @(negedge clk);
    #1;
    chk("arst pre ov", ov, 1);
    chk("arst pre od", od, 'h0222);
    chk("arst pre ol", ol, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst ov", ov, 0);
    chk("arst od", od, 0);
    chk("arst ol", ol, 0);
    chk("arst rdy", rdy, 0);
    chk("arst cnt", cnt, 0);
    chk("arst ovf", ovf, 0);
    chk("arst wa", wa, 0);
    chk("arst ra", ra, 0);
    chk("arst we", we, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1 chk($sformatf("post arst ov%0d", i), ov, 0);
    end

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      s_lv = 1'b1;
      s_lt = 16'(i + 1);
      #1;
      chk($sformatf("s we%0d", i), s_we, i < 4);
      chk($sformatf("s wa%0d", i), s_wa, i & 3);
    end
    @(negedge clk);
    s_lv = 1'b0;
    #1;
    chk("s cnt full", s_cnt, 4);
    chk("s ovf", s_ovf, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      s_rn = 1'b1;
      #1 chk($sformatf("s rdy%0d", i), s_rdy, 1);
      @(negedge clk);
      s_rn = 1'b0;
      @(negedge clk);
      #1;
      chk($sformatf("s ov%0d", i), s_ov, 1);
      chk($sformatf("s od%0d", i), s_od, (i % 4) + 1);
      chk($sformatf("s ol%0d", i), s_ol, i == 3);
    end
    @(negedge clk);
    s_clr = 1'b1;
    @(negedge clk);
    s_clr = 1'b0;
    #1;
    chk("s clr ovf", s_ovf, 0);
    chk("s clr cnt", s_cnt, 0);
    chk("s clr rdy", s_rdy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
